key_debounce: RTL
=================

# key_debounce

Debounces and edge-qualifies the raw DE2 push-buttons before they reach the top-level playback/record control FSM. For each key, it produces:
- a clean pressed level,
- a single-cycle press pulse,
- a single-cycle release pulse,
- optionally, a single-cycle long-press pulse.

These outputs replace the ad-hoc "key_up" tracking in the controller. It runs in the audio bit-clock domain, alongside the control FSM, and sits directly upstream of it.

## Interface
- N_KEYS, 3: number of independent keys.
- DEBOUNCE_CYCLES, 240000: stable-sample count required to accept a level change (20 ms at 12 MHz); legal range ≥ 2.
- LONG_CYCLES, 24000000: held count, measured from the debounced press, that triggers a long press (2 s); must exceed DEBOUNCE_CYCLES.
- i_clk  in  1  audio bit clock (AUD_BCLK); only clock.
- i_rst  in  1  synchronous reset, active-high.
- i_key  in  N_KEYS  raw asynchronous buttons, active-low (0 = pressed).
- o_level  out  N_KEYS  debounced state, active-high (1 = pressed).
- o_press  out  N_KEYS  one-cycle pulse on accepted press.
- o_release  out  N_KEYS  one-cycle pulse on accepted release.
- o_long  out  N_KEYS  one-cycle pulse on long press; tied 0 when the feature is compiled out.

## Operation
- Each key is fully independent. Several keys may pulse in the same cycle.
- Each key has a two-flop synchronizer on the raw input, with s2 as its output. All decisions use s2. p = !s2.
- Each key has a per-key FSM with states UP, DOWN_WAIT, DOWN and UP_WAIT, plus a counter cnt.
  - UP: if p, go to DOWN_WAIT with cnt = 0.
  - DOWN_WAIT:
    - if !p, go to UP (glitch rejected; no pulse).
    - else if cnt == DEBOUNCE_CYCLES-1, go to DOWN, set o_level = 1, pulse o_press, and clear the hold counter.
    - else cnt++.
  - DOWN: if !p, go to UP_WAIT with cnt = 0. Otherwise the hold counter runs (see Configuration).
  - UP_WAIT:
    - if p, go to DOWN (bounce rejected; no pulse; o_level stays 1; hold counter continues without reset).
    - else if cnt == DEBOUNCE_CYCLES-1, go to UP, set o_level = 0, and pulse o_release.
    - else cnt++.
- Counter width is $clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)+1). The counters never wrap: the debounce counter exits before terminal count, and the hold counter saturates.
- Reset, including mid-press or mid-debounce:
  - synchronizer flops go to 1 (released);
  - all FSMs go to UP;
  - counters go to 0;
  - every output is 0.
- A key held through reset is treated as a new press. It yields o_press after the normal latency.
- o_press and o_release for the same key never occur in the same cycle.
- o_press always precedes o_release, and they alternate strictly per key.

## Timing
- All outputs are registered. Define edge 0 as the first rising edge at which i_key[k] is sampled low.
- Press latency:
  - s2 is low after edge 1;
  - DOWN_WAIT is entered at edge 2;
  - o_press[k] and o_level[k] rise after edge DEBOUNCE_CYCLES+2.
- Release latency is symmetric: o_release[k] pulses and o_level[k] falls after edge DEBOUNCE_CYCLES+2, counted from the first edge that samples i_key high.
- Pulses are exactly one i_clk cycle wide.
- Any input interval shorter than DEBOUNCE_CYCLES cycles (after synchronization) produces no output change.

## Configuration
- KEY_DEBOUNCE_LONG_PRESS_EN defined:
  - in DOWN, the hold counter increments each cycle, starting from 0 at the o_press cycle;
  - when it reaches LONG_CYCLES-1, o_long[k] pulses once and the counter saturates;
  - no repeat until the next accepted press.
- KEY_DEBOUNCE_LONG_PRESS_EN undefined:
  - the hold counter logic is absent;
  - o_long is constant 0;
  - LONG_CYCLES is ignored and not range-checked.

## Structure
- Package key_debounce_pkg:
  - key_state_e enum (UP, DOWN_WAIT, DOWN, UP_WAIT, 2-bit);
  - default cycle constants;
  - a count-width function.
- Sub-module key_debounce_ch: one key's synchronizer, FSM and counters. The top instantiates it N_KEYS times in a generate loop.
- The top performs parameter sanity checks with elaboration-time $error.

## Test plan
Bench parameters: DEBOUNCE_CYCLES = 4, LONG_CYCLES = 16, macro defined.
- Clean press and release: drive i_key[0] low at edge 0 and hold for 30 cycles, then high.
  - o_press[0] is high for exactly the cycle after edge 6.
  - o_long[0] pulses 16 cycles after o_press.
  - o_release[0] pulses 6 edges after release.
  - Other keys stay 0.
- Glitch rejection: drive i_key[1] low for 3 cycles, then high.
  - No pulse on any output.
  - o_level[1] stays 0.
- Release bounce: hold the key for 20 cycles, go high for 2 cycles, then low again.
  - No o_release.
  - o_level stays 1.
  - o_long still pulses at 16 cycles from o_press.
- Simultaneous keys: drive all three keys low on the same edge.
  - o_press equals 3'b111 in one cycle.
  - A later simultaneous release gives o_release equal to 3'b111.
- Reset mid-operation: assert i_rst in DOWN_WAIT while the key is held, then deassert.
  - Outputs are 0 during reset.
  - o_press appears 7 edges after reset release, since the key is still low.
- Macro undefined: repeat the clean press and release with a 40-cycle hold.
  - o_long is never 1.
  - Press and release timing is unchanged.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
// Optional long-press detection is enabled by defining KEY_DEBOUNCE_LONG_PRESS_EN.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    UP        = 2'd0,
    DOWN_WAIT = 2'd1,
    DOWN      = 2'd2,
    UP_WAIT   = 2'd3
  } key_state_e;

  localparam int DEF_N_KEYS          = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 240000;   // 20 ms at 12 MHz
  localparam int DEF_LONG_CYCLES     = 24000000; // 2 s at 12 MHz

  // Wide enough to hold the larger of the two terminal counts plus one.
  function automatic int cnt_width(input int debounce_cycles, input int long_cycles);
    int max_cycles;
    max_cycles = (debounce_cycles > long_cycles) ? debounce_cycles : long_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key: two-flop synchronizer, debounce FSM and (with KEY_DEBOUNCE_LONG_PRESS_EN)
// a saturating hold counter that emits a single long-press pulse.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
`endif
  parameter int CW              = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key,
  output logic       o_level,
  output logic       o_press,
  output logic       o_release,
  output logic       o_long,
  output logic [1:0] o_state
);

  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic s1;
  logic s2;
  logic p;

  // Raw button is asynchronous; resetting to 1 means "released".
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= i_key;
      s2 <= s1;
    end
  end

  assign p = ~s2;

  key_state_e    state;
  key_state_e    state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          level_nx;
  logic          press_nx;
  logic          release_nx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= UP;
      cnt       <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      o_level   <= level_nx;
      o_press   <= press_nx;
      o_release <= release_nx;
    end
  end

  // The debounce counter always leaves its state at DEB_LAST, so it never wraps.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    level_nx   = o_level;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    case (state)
      UP: begin
        if (p) begin
          state_nx = DOWN_WAIT;
          cnt_nx   = '0;
        end
      end
      DOWN_WAIT: begin
        if (!p) begin
          state_nx = UP;
        end else if (cnt == DEB_LAST) begin
          state_nx = DOWN;
          level_nx = 1'b1;
          press_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DOWN: begin
        if (!p) begin
          state_nx = UP_WAIT;
          cnt_nx   = '0;
        end
      end
      UP_WAIT: begin
        if (p) begin
          state_nx = DOWN;
        end else if (cnt == DEB_LAST) begin
          state_nx   = UP;
          level_nx   = 1'b0;
          release_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = UP;
      end
    endcase
  end

  assign o_state = state;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYCLES);

  logic [CW-1:0] hold;

  // Hold counter restarts with each accepted press and parks at LONG_SAT,
  // which makes the long pulse fire exactly once per press.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold   <= '0;
      o_long <= 1'b0;
    end else begin
      o_long <= 1'b0;
      if (press_nx) begin
        hold <= '0;
      end else if (state == DOWN && hold != LONG_SAT) begin
        hold   <= hold + CW'(1);
        o_long <= (hold == LONG_LAST);
      end
    end
  end
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Debounce and edge-qualify N_KEYS active-low push-buttons in the bit-clock domain.
// Long-press pulses exist only when KEY_DEBOUNCE_LONG_PRESS_EN is defined.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS          = DEF_N_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_KEYS-1:0]     i_key,
  output logic [N_KEYS-1:0]     o_level,
  output logic [N_KEYS-1:0]     o_press,
  output logic [N_KEYS-1:0]     o_release,
  output logic [N_KEYS-1:0]     o_long,
  output logic [2*N_KEYS-1:0]   o_state
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);

  if (N_KEYS < 1) begin : g_bad_n_keys
    $error("key_debounce: N_KEYS must be at least 1");
  end

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("key_debounce: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end
`endif

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
      .LONG_CYCLES     (LONG_CYCLES),
`endif
      .CW              (CW)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_key     (i_key[k]),
      .o_level   (o_level[k]),
      .o_press   (o_press[k]),
      .o_release (o_release[k]),
      .o_long    (o_long[k]),
      .o_state   (o_state[2*k+1:2*k])
    );
  end

endmodule
